// File: rtl/scanconv_pkg.sv
// Scan-converter shared definitions: default timing constants, border
// geometry and the common counter type used by the line doubler.
package scanconv_pkg;

    // Width of every timing / address counter in the doubler.
    localparam int CNT_W = 11;
    typedef logic [CNT_W-1:0] cnt_t;

    // Default video timing (12 MHz output clock, ~31 kHz line rate).
    localparam int DEF_PIX_W      = 8;
    localparam int DEF_LINE_W     = 512;
    localparam int DEF_OUT_HTOTAL = 383;
    localparam int DEF_HS_START   = 329;
    localparam int DEF_HS_END     = 376;
    localparam int DEF_VS_START   = 508;
    localparam int DEF_VS_LEN     = 2;

    // Border test-pattern geometry (used only when the border is compiled in).
    localparam int BORDER_LEFT   = 16;
    localparam int BORDER_RIGHT  = 32;
    localparam int BORDER_TOP    = 40;
    localparam int BORDER_BOTTOM = 500;

endpackage

// File: rtl/scanconv_linebuf.sv
// Two-bank line buffer: simple dual-port RAM, one write port and one
// synchronously read port, both on clk12m.
module scanconv_linebuf
    import scanconv_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W,
    parameter int DEPTH = 2 * DEF_LINE_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk12m,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [PIX_W-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [PIX_W-1:0] o_rdata
);

    logic [PIX_W-1:0] r_mem [DEPTH];
    logic [PIX_W-1:0] r_rdata;

    // Write the incoming pixel and register the read word (1-cycle latency).
    // NOTE: the storage array has no reset branch; a reset would force it into
    // flops instead of RAM, and stale contents are never shown because the
    // read side blanks everything beyond the stored line length.
    always_ff @(posedge clk12m) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/scanconv_doubler.sv
// Scan doubler: stores one 15 kHz input line per bank and replays it twice
// on a free-running 31 kHz output raster resynchronised by the input syncs.
// Optional feature: define SCANCONV_BORDER_EN to overlay a border pattern.
module scanconv_doubler
    import scanconv_pkg::*;
#(
    parameter int PIX_W      = DEF_PIX_W,
    parameter int LINE_W     = DEF_LINE_W,
    parameter int OUT_HTOTAL = DEF_OUT_HTOTAL,
    parameter int HS_START   = DEF_HS_START,
    parameter int HS_END     = DEF_HS_END,
    parameter int VS_START   = DEF_VS_START,
    parameter int VS_LEN     = DEF_VS_LEN
) (
    input  logic             clk12m,
    input  logic             reset,
    input  logic             pix_ce_i,
    input  logic             hsync_i,
    input  logic             vsync_i,
    input  logic             blank_i,
    input  logic [PIX_W-1:0] rgb_i,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             blank_o,
    output logic [PIX_W-1:0] rgb_o
);

    localparam int AW = $clog2(2 * LINE_W);
    localparam int XW = AW - 1;

    localparam cnt_t WCNT_SAT = cnt_t'(LINE_W - 1);
    localparam cnt_t HTOT_M1  = cnt_t'(OUT_HTOTAL - 1);
    localparam cnt_t HS_S     = cnt_t'(HS_START);
    localparam cnt_t HS_E     = cnt_t'(HS_END);
    localparam cnt_t VS_S     = cnt_t'(VS_START);
    localparam cnt_t VS_E     = cnt_t'(VS_START + VS_LEN);

    logic             r_hs_prev, r_vs_prev;
    cnt_t             r_hcnt, r_vcnt, r_wcnt, r_wlen;
    logic             r_wbank;
    logic             r_vis1, r_hs1, r_vs1;

    logic             w_hs_fall, w_vs_fall, w_hwrap, w_we;
    logic             w_vis, w_hs_act, w_vs_act, w_blank1;
    logic [AW-1:0]    w_waddr, w_raddr;
    logic [PIX_W-1:0] w_rdata, w_rgb_next;

    assign w_hs_fall = r_hs_prev & ~hsync_i;
    assign w_vs_fall = r_vs_prev & ~vsync_i;
    // A resync in the wrap cycle moves hcnt to HS_END, so it is not a wrap.
    assign w_hwrap   = (r_hcnt == HTOT_M1) & ~w_hs_fall;

    // Keep last cycle's sync levels for falling-edge detection.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk12m) begin
        if (reset) begin
            r_hs_prev <= 1'b0;
            r_vs_prev <= 1'b0;
        end else begin
            r_hs_prev <= hsync_i;
            r_vs_prev <= vsync_i;
        end
    end

    // Write side: pixels land at (wbank, wcnt); the last slot is a sink for overflow.
    assign w_we    = pix_ce_i & ~blank_i & ~w_hs_fall & (r_wcnt != WCNT_SAT);
    assign w_waddr = {r_wbank, r_wcnt[XW-1:0]};

    // Line bookkeeping: latch the finished line length and swap banks on hsync.
    always_ff @(posedge clk12m) begin
        if (reset) begin
            r_wcnt  <= '0;
            r_wlen  <= '0;
            r_wbank <= 1'b0;
        end else if (w_hs_fall) begin
            r_wlen  <= r_wcnt;
            r_wcnt  <= '0;
            r_wbank <= ~r_wbank;
        end else if (w_we) begin
            r_wcnt  <= r_wcnt + cnt_t'(1);
        end
    end

    // Output raster counters, free-running and pulled in by the input syncs.
    always_ff @(posedge clk12m) begin
        if (reset) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else begin
            if (w_hs_fall) begin
                r_hcnt <= HS_E;
            end else if (r_hcnt == HTOT_M1) begin
                r_hcnt <= '0;
            end else begin
                r_hcnt <= r_hcnt + cnt_t'(1);
            end
            if (w_vs_fall) begin
                r_vcnt <= '0;
            end else if (w_hwrap) begin
                r_vcnt <= r_vcnt + cnt_t'(1);
            end
        end
    end

    // Read side: replay the bank that is not being written.
    assign w_raddr  = {~r_wbank, r_hcnt[XW-1:0]};
    assign w_vis    = (r_hcnt < r_wlen);
    assign w_hs_act = (r_hcnt >= HS_S) && (r_hcnt < HS_E);
    assign w_vs_act = (r_vcnt >= VS_S) && (r_vcnt < VS_E);

    scanconv_linebuf #(
        .PIX_W (PIX_W),
        .DEPTH (2 * LINE_W),
        .AW    (AW)
    ) u_linebuf (
        .clk12m  (clk12m),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (rgb_i),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // Stage 1: carry the raster decode alongside the RAM read.
    always_ff @(posedge clk12m) begin
        if (reset) begin
            r_vis1 <= 1'b0;
            r_hs1  <= 1'b0;
            r_vs1  <= 1'b0;
        end else begin
            r_vis1 <= w_vis;
            r_hs1  <= w_hs_act;
            r_vs1  <= w_vs_act;
        end
    end

    assign w_blank1 = ~r_vis1 | r_hs1 | r_vs1;

`ifdef SCANCONV_BORDER_EN
    localparam cnt_t BDR_L = cnt_t'(BORDER_LEFT);
    localparam cnt_t BDR_R = cnt_t'(OUT_HTOTAL - BORDER_RIGHT);
    localparam cnt_t BDR_T = cnt_t'(BORDER_TOP);
    localparam cnt_t BDR_B = cnt_t'(BORDER_BOTTOM);

    logic             r_bdr1;
    logic [PIX_W-1:0] r_hpix1;
    logic             w_bdr;

    assign w_bdr = ((r_hcnt < BDR_L) || (r_hcnt >= BDR_R) ||
                    (r_vcnt < BDR_T) || (r_vcnt > BDR_B)) && !w_hs_act && !w_vs_act;

    // Stage 1 border flag and pattern value, aligned with the RAM read.
    always_ff @(posedge clk12m) begin
        if (reset) begin
            r_bdr1  <= 1'b0;
            r_hpix1 <= '0;
        end else begin
            r_bdr1  <= w_bdr;
            r_hpix1 <= r_hcnt[PIX_W-1:0];
        end
    end

    assign w_rgb_next = r_bdr1 ? r_hpix1 : (w_blank1 ? '0 : w_rdata);
`else
    assign w_rgb_next = w_blank1 ? '0 : w_rdata;
`endif

    // Stage 2: registered, mutually aligned video outputs.
    always_ff @(posedge clk12m) begin
        if (reset) begin
            hsync_o <= 1'b1;
            vsync_o <= 1'b1;
            blank_o <= 1'b1;
            rgb_o   <= '0;
        end else begin
            hsync_o <= ~r_hs1;
            vsync_o <= ~r_vs1;
            blank_o <= w_blank1;
            rgb_o   <= w_rgb_next;
        end
    end

endmodule

// File: tb/tb_scanconv_doubler.sv
// Directed bench for scanconv_doubler. A second instance with an early
// vsync window lets the vsync behaviour be seen within a short run.
module tb_scanconv_doubler;

    localparam int HT  = 383;
    localparam int HSS = 329;
    localparam int HSE = 376;
    localparam int VS1 = 508;
    localparam int VS2 = 6;

`ifdef SCANCONV_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    logic       clk12m   = 1'b0;
    logic       reset    = 1'b1;
    logic       pix_ce_i = 1'b0;
    logic       hsync_i  = 1'b1;
    logic       vsync_i  = 1'b1;
    logic       blank_i  = 1'b1;
    logic [7:0] rgb_i    = 8'h00;

    logic       hsync_o, vsync_o, blank_o;
    logic [7:0] rgb_o;
    logic       hsync2, vsync2, blank2;
    logic [7:0] rgb2;

    int n_cmp = 0;
    int n_bad = 0;

    // Bench-side raster model: current counters plus the two-cycle delayed
    // values that the outputs correspond to.
    int   hcnt_m = 0, vcnt_m = 0;
    int   h_d1 = 0, h_d2 = 0, v_d1 = 0, v_d2 = 0, vld = 0;
    logic hs_prev_m = 1'b0, vs_prev_m = 1'b0;

    scanconv_doubler u_dut (
        .clk12m (clk12m), .reset (reset), .pix_ce_i (pix_ce_i),
        .hsync_i (hsync_i), .vsync_i (vsync_i), .blank_i (blank_i), .rgb_i (rgb_i),
        .hsync_o (hsync_o), .vsync_o (vsync_o), .blank_o (blank_o), .rgb_o (rgb_o)
    );

    scanconv_doubler #(.VS_START (VS2), .VS_LEN (2)) u_dut_vs (
        .clk12m (clk12m), .reset (reset), .pix_ce_i (pix_ce_i),
        .hsync_i (hsync_i), .vsync_i (vsync_i), .blank_i (blank_i), .rgb_i (rgb_i),
        .hsync_o (hsync2), .vsync_o (vsync2), .blank_o (blank2), .rgb_o (rgb2)
    );

    always #5 clk12m = ~clk12m;

    initial begin
        #2ms;
        $display("FAIL watchdog: run did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic hswin(int h);
        return (h >= HSS) && (h < HSE);
    endfunction

    function automatic logic [7:0] pv(int j);
        return 8'(j / 3 + 7);
    endfunction

    // Expected rgb including the optional border overlay.
    function automatic logic [7:0] exp_rgb(int h, int v, logic hs, logic vs, logic [7:0] base);
        logic bdr;
        bdr = ((h < 16) || (h >= HT - 32) || (v < 40) || (v > 500)) && !hs && !vs;
        return (BORDER && bdr) ? 8'(h) : base;
    endfunction

    task automatic tick();
        logic hs_fall, vs_fall;
        @(posedge clk12m);
        h_d2 = h_d1; v_d2 = v_d1;
        h_d1 = hcnt_m; v_d1 = vcnt_m;
        if (reset) begin
            hcnt_m = 0; vcnt_m = 0; hs_prev_m = 1'b0; vs_prev_m = 1'b0; vld = 0;
        end else begin
            hs_fall = hs_prev_m & ~hsync_i;
            vs_fall = vs_prev_m & ~vsync_i;
            if (vs_fall) vcnt_m = 0;
            else if (hcnt_m == HT - 1 && !hs_fall) vcnt_m = vcnt_m + 1;
            if (hs_fall) hcnt_m = HSE;
            else if (hcnt_m == HT - 1) hcnt_m = 0;
            else hcnt_m = hcnt_m + 1;
            hs_prev_m = hsync_i;
            vs_prev_m = vsync_i;
            if (vld < 2) vld = vld + 1;
        end
        #1;
    endtask

    task automatic feed_line(int n, int kind);
        blank_i = 1'b0;
        for (int j = 0; j < n; j++) begin
            pix_ce_i = 1'b1;
            rgb_i    = (kind == 0) ? 8'h5A : (kind == 1) ? pv(j) : 8'(8'h10 + j);
            tick();
            pix_ce_i = 1'b0;
            tick();
        end
        blank_i = 1'b1;
    endtask

    task automatic hsync_fall_and_align();
        hsync_i = 1'b0;
        tick();
        hsync_i = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        logic [10:0] exp;
        logic        hs;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if ({hsync_o, vsync_o, blank_o, rgb_o} !== 11'h700 ||
                {hsync2, vsync2, blank2, rgb2} !== 11'h700) begin
                n_bad++;
                $display("FAIL reset_hold c=%0d got=%h/%h exp=700", c,
                         {hsync_o, vsync_o, blank_o, rgb_o}, {hsync2, vsync2, blank2, rgb2});
            end
        end
        reset = 1'b0;
        // First output line after reset: nothing stored yet, so fully blanked.
        for (int c = 0; c < HT; c++) begin
            tick();
            hs  = (vld >= 2) && hswin(h_d2);
            exp = {~hs, 1'b1, 1'b1, (vld >= 2) ? exp_rgb(h_d2, v_d2, hs, 1'b0, 8'h00) : 8'h00};
            n_cmp++;
            if ({hsync_o, vsync_o, blank_o, rgb_o} !== exp ||
                {hsync2, vsync2, blank2, rgb2} !== exp) begin
                n_bad++;
                $display("FAIL first_line h=%0d got=%h/%h exp=%h", h_d2,
                         {hsync_o, vsync_o, blank_o, rgb_o}, {hsync2, vsync2, blank2, rgb2}, exp);
            end
        end
    endtask

    task automatic test_line_5a();
        logic [10:0] exp;
        logic        hs, vis;
        feed_line(256, 0);
        hsync_fall_and_align();
        // Tail of the resync line (376..382) then two full doubled lines.
        for (int c = 0; c < 7 + 2 * HT; c++) begin
            hs  = hswin(h_d2);
            vis = (h_d2 < 256) && !hs;
            exp = {~hs, 1'b1, ~vis, exp_rgb(h_d2, v_d2, hs, 1'b0, vis ? 8'h5A : 8'h00)};
            n_cmp++;
            if ({hsync_o, vsync_o, blank_o, rgb_o} !== exp) begin
                n_bad++;
                $display("FAIL line_5a h=%0d got=%h exp=%h", h_d2,
                         {hsync_o, vsync_o, blank_o, rgb_o}, exp);
            end
            tick();
        end
    endtask

    task automatic test_overflow();
        logic [10:0] exp;
        logic        hs;
        feed_line(600, 1);
        hsync_fall_and_align();
        // wlen saturates at 511, so every non-sync position up to 382 is
        // visible and must still hold pixel h, not an overflow pixel.
        for (int c = 0; c < 7 + 2 * HT; c++) begin
            hs  = hswin(h_d2);
            exp = {~hs, 1'b1, hs, exp_rgb(h_d2, v_d2, hs, 1'b0, hs ? 8'h00 : pv(h_d2))};
            n_cmp++;
            if ({hsync_o, vsync_o, blank_o, rgb_o} !== exp) begin
                n_bad++;
                $display("FAIL overflow h=%0d got=%h exp=%h", h_d2,
                         {hsync_o, vsync_o, blank_o, rgb_o}, exp);
            end
            tick();
        end
    endtask

    task automatic test_hsync_resync();
        logic [10:0] exp;
        logic        hs, vis;
        feed_line(40, 2);
        for (int c = 0; c < 2 * HT && hcnt_m != 100; c++) tick();
        hsync_fall_and_align();
        // Output for hcnt=376, the first position after the jump.
        n_cmp++;
        if (hsync_o !== 1'b1 || blank_o !== 1'b1) begin
            n_bad++;
            $display("FAIL resync_376 got hs=%b bl=%b exp hs=1 bl=1", hsync_o, blank_o);
        end
        // 376..382 blanked, then the 40-pixel line starts exactly at hcnt 0.
        for (int c = 0; c < 7 + 60; c++) begin
            hs  = hswin(h_d2);
            vis = (h_d2 < 40) && !hs;
            exp = {~hs, 1'b1, ~vis, exp_rgb(h_d2, v_d2, hs, 1'b0, vis ? 8'(8'h10 + h_d2) : 8'h00)};
            n_cmp++;
            if ({hsync_o, vsync_o, blank_o, rgb_o} !== exp) begin
                n_bad++;
                $display("FAIL resync h=%0d got=%h exp=%h", h_d2,
                         {hsync_o, vsync_o, blank_o, rgb_o}, exp);
            end
            tick();
        end
    endtask

    task automatic test_vsync();
        logic [10:0] exp1, exp2;
        logic        hs, vis, vs1, vs2;
        int          n_low;
        for (int c = 0; c < 2 * HT && hcnt_m != HT - 1; c++) tick();
        // vsync fall in the wrap cycle: vcnt must restart at 0, not 1.
        vsync_i = 1'b0;
        tick();
        vsync_i = 1'b1;
        tick();
        tick();
        n_low = 0;
        for (int c = 0; c < 10 * HT; c++) begin
            hs   = hswin(h_d2);
            vs1  = (v_d2 >= VS1) && (v_d2 < VS1 + 2);
            vs2  = (v_d2 >= VS2) && (v_d2 < VS2 + 2);
            vis  = (h_d2 < 40) && !hs;
            exp1 = {~hs, ~vs1, ~(vis && !vs1),
                    exp_rgb(h_d2, v_d2, hs, vs1, (vis && !vs1) ? 8'(8'h10 + h_d2) : 8'h00)};
            exp2 = {~hs, ~vs2, ~(vis && !vs2),
                    exp_rgb(h_d2, v_d2, hs, vs2, (vis && !vs2) ? 8'(8'h10 + h_d2) : 8'h00)};
            n_cmp++;
            if ({hsync_o, vsync_o, blank_o, rgb_o} !== exp1 ||
                {hsync2, vsync2, blank2, rgb2} !== exp2) begin
                n_bad++;
                $display("FAIL vsync v=%0d h=%0d got=%h/%h exp=%h/%h", v_d2, h_d2,
                         {hsync_o, vsync_o, blank_o, rgb_o}, {hsync2, vsync2, blank2, rgb2},
                         exp1, exp2);
            end
            if (vsync2 === 1'b0) n_low++;
            tick();
        end
        n_cmp++;
        if (n_low != 2 * HT) begin
            n_bad++;
            $display("FAIL vsync_len got=%0d cycles exp=%0d", n_low, 2 * HT);
        end
    endtask

`ifdef SCANCONV_BORDER_EN
    task automatic test_border();
        for (int c = 0; c < 2 * HT && h_d2 != 5; c++) tick();
        n_cmp++;
        if (rgb_o !== 8'h05) begin
            n_bad++;
            $display("FAIL border h=%0d got=%h exp=05", h_d2, rgb_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_line_5a();
        test_overflow();
        test_hsync_resync();
        test_vsync();
`ifdef SCANCONV_BORDER_EN
        test_border();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/scanconv_doubler.md
SCANCONV_DOUBLER -- requirements
Module: scanconv_doubler

Interface
REQ-001 The block SHALL have parameter PIX_W, default 8, meaning pixel width in bits.
REQ-002 The block SHALL have parameter LINE_W, default 512, meaning max stored pixels per input line (power of 2).
REQ-003 The block SHALL have parameter OUT_HTOTAL, default 383, meaning output line length in clk12m cycles.
REQ-004 The block SHALL have parameters HS_START=329 and HS_END=376, meaning the output hsync window [HS_START,HS_END) in hcnt.
REQ-005 The block SHALL have parameters VS_START=508 and VS_LEN=2, meaning the output vsync window in output lines.
REQ-006 The block SHALL have port clk12m, input, 1 bit: the single clock.
REQ-007 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have port pix_ce_i, input, 1 bit: input pixel strobe (6 MHz rate, one clk12m cycle wide).
REQ-009 The block SHALL have ports hsync_i, input, 1 bit and vsync_i, input, 1 bit: active-low input syncs.
REQ-010 The block SHALL have port blank_i, input, 1 bit: input blanking, high = not visible.
REQ-011 The block SHALL have port rgb_i, input, PIX_W bits: input pixel.
REQ-012 The block SHALL have ports hsync_o, output, 1 bit and vsync_o, output, 1 bit: active-low doubled-rate syncs.
REQ-013 The block SHALL have port blank_o, output, 1 bit: output blanking.
REQ-014 The block SHALL have port rgb_o, output, PIX_W bits: output pixel.

Function
REQ-015 hsync_i/vsync_i SHALL be registered every clk12m cycle; a fall is prev=1 & cur=0.
REQ-016 Write: on pix_ce_i & ~blank_i & no hsync fall, store rgb_i at (wbank, wcnt); wcnt increments and saturates at LINE_W-1, dropping excess pixels.
REQ-017 On hsync fall: wlen <= wcnt, wcnt <= 0, wbank toggles; a pixel strobed in that cycle is dropped.
REQ-018 hcnt SHALL count 0..OUT_HTOTAL-1 and wrap; on hsync fall hcnt <= HS_END (resync overrides wrap).
REQ-019 vcnt SHALL increment on hcnt wrap; on vsync fall vcnt <= 0, overriding a simultaneous wrap.
REQ-020 Read: address (~wbank, hcnt) when hcnt < wlen, so each input line is emitted on two consecutive output lines.
REQ-021 RAM read latency is 1 cycle; rgb_o, hsync_o, vsync_o and blank_o SHALL all be registered and mutually aligned (total latency 2 cycles from hcnt).
REQ-022 hsync_o=0 iff HS_START<=hcnt<HS_END; vsync_o=0 iff VS_START<=vcnt<VS_START+VS_LEN.
REQ-023 blank_o=1 and rgb_o=0 when hcnt>=wlen or hsync_o or vsync_o is active.
REQ-024 With no input syncs, timing SHALL free-run; the last wlen is reused.

Reset
REQ-025 On reset, hsync_o=1, vsync_o=1, blank_o=1, rgb_o=0, and hcnt, vcnt, wcnt, wlen, wbank and the sync registers =0; RAM contents are not reset.
REQ-026 Reset mid-line SHALL abort the write; the first line after reset SHALL be fully blanked (wlen=0).

Configuration
REQ-027 With SCANCONV_BORDER_EN defined, rgb_o SHALL be overridden by hcnt[PIX_W-1:0] (not blanked) when hcnt<16, hcnt>=OUT_HTOTAL-32, vcnt<40 or vcnt>500, outside sync windows.
REQ-028 With SCANCONV_BORDER_EN undefined, no border logic SHALL be present.

Structure
REQ-029 Package scanconv_pkg SHALL hold the default timing constants and the counter-width typedef (11 bits).
REQ-030 The sub-module scanconv_linebuf SHALL be a 2*LINE_W x PIX_W simple dual-port RAM with synchronous read.

Verification
REQ-031 Reset held for 3 cycles -> outputs are 1/1/1/0 throughout reset and the first output line.
REQ-032 Input line of 256 pixels of value 8'h5A, then hsync fall -> the next two output lines carry 256 cycles of 8'h5A at hcnt 0..255, blank_o=1 at hcnt>=256.
REQ-033 Input line of 600 pixels -> wlen=511 and pixels 511..599 are not written.
REQ-034 vsync fall coinciding with hcnt=382 -> vcnt=0, and vsync_o goes low at output line 508 for exactly 2 lines.
REQ-035 hsync fall at hcnt=100 -> hcnt=376 on the next cycle, and hsync_o is high there.
REQ-036 With SCANCONV_BORDER_EN defined, at hcnt=5 and vcnt=200 -> rgb_o=8'h05.
